// File: rtl/ecpri_pkg.sv
// Shared eCPRI response-scheduler types: response type codes, FSM encodings and a
// saturating counter helper.
package ecpri_pkg;

  localparam logic RESP_READ  = 1'b0;
  localparam logic RESP_WRITE = 1'b1;

  // 8-bit encodings keep these states in line with the other eCPRI FSMs on the debug bus.
  typedef enum logic [7:0] {
    ST_IDLE      = 8'h00,
    ST_ISSUE     = 8'h01,
    ST_WAIT_DONE = 8'h02,
    ST_GAP       = 8'h03
  } sched_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/ecpri_resp_sched_if.sv
// Request/TX handshake bundle between ecpri_rx, the response scheduler and the TX builder.
interface ecpri_resp_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  send_write_resp;
  logic                  send_read_resp;
  logic [DATA_WIDTH-1:0] resp_payload_len;
  logic                  tx_done;
  logic                  tx_start;
  logic                  tx_type;
  logic [DATA_WIDTH-1:0] tx_len;

  modport slave (
    input  send_write_resp, send_read_resp, resp_payload_len, tx_done,
    output tx_start, tx_type, tx_len
  );

  modport master (
    output send_write_resp, send_read_resp, resp_payload_len, tx_done,
    input  tx_start, tx_type, tx_len
  );
endinterface

// File: rtl/ecpri_resp_fifo.sv
// Synchronous FIFO of response descriptors; a push on a full FIFO is accepted when a pop
// happens in the same cycle.
module ecpri_resp_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ecpri_resp_sched.sv
// Response scheduler: turns ecpri_rx request levels into queued responses and drives the
// TX builder one response at a time with a start/done handshake, gap and timeout.
module ecpri_resp_sched
  import ecpri_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  ecpri_resp_sched_if.slave      rif,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   timeout_err
);
  localparam int         EW       = DATA_WIDTH + 1;
  localparam logic [7:0] GAP_LOAD = 8'(IFG_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT);

  typedef struct packed {
    logic                  typ;
    logic [DATA_WIDTH-1:0] len;
  } entry_t;

  sched_state_e          state_q, state_d;
  logic                  wr_in_q, rd_in_q;
  logic                  skid_vld_q, skid_vld_d;
  entry_t                skid_q, skid_d;
  logic                  tx_type_q, tx_type_d;
  logic [DATA_WIDTH-1:0] tx_len_q, tx_len_d;
  logic [7:0]            tmo_q, tmo_d, gap_q, gap_d, drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d;

  logic                  wr_edge, rd_edge, cand_vld, push, pop, fifo_full, fifo_empty;
  logic [1:0]            n_drop;
  entry_t                cand, wr_ent, rd_ent, head;
  logic [EW-1:0]         head_raw;

  ecpri_resp_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cand),
    .pop       (pop),
    .pop_data  (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  assign head = head_raw;

  // One queue write per cycle: a waiting skid entry goes first, then write, then read.
  always_comb begin
    wr_edge    = rif.send_write_resp & ~wr_in_q;
    rd_edge    = rif.send_read_resp & ~rd_in_q;
    wr_ent     = '{typ: RESP_WRITE, len: '0};
    rd_ent     = '{typ: RESP_READ, len: rif.resp_payload_len};
    cand_vld   = 1'b0;
    cand       = wr_ent;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    n_drop     = 2'd0;
    if (skid_vld_q) begin
      cand_vld   = 1'b1;
      cand       = skid_q;
      skid_vld_d = 1'b0;
      if (wr_edge) begin
        skid_vld_d = 1'b1;
        skid_d     = wr_ent;
        if (rd_edge) n_drop = 2'd1;
      end else if (rd_edge) begin
        skid_vld_d = 1'b1;
        skid_d     = rd_ent;
      end
    end else if (wr_edge) begin
      cand_vld = 1'b1;
      if (rd_edge) begin
        skid_vld_d = 1'b1;
        skid_d     = rd_ent;
      end
    end else if (rd_edge) begin
      cand_vld = 1'b1;
      cand     = rd_ent;
    end
    push = cand_vld && (!fifo_full || pop);
    if (cand_vld && !push) n_drop = n_drop + 2'd1;
    overflow_d = overflow_q | (n_drop != 2'd0);
    drop_cnt_d = sat_add8(drop_cnt_q, n_drop);
  end

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    tx_type_d   = tx_type_q;
    tx_len_d    = tx_len_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    pop         = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_type_d = head.typ;
          tx_len_d  = head.len;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (rif.tx_done) begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err = 1'b1;
          gap_d       = GAP_LOAD;
          state_d     = ST_GAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_in_q    <= 1'b0;
      rd_in_q    <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      tx_type_q  <= 1'b0;
      tx_len_q   <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_in_q    <= rif.send_write_resp;
      rd_in_q    <= rif.send_read_resp;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      tx_type_q  <= tx_type_d;
      tx_len_q   <= tx_len_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rif.tx_start = (state_q == ST_ISSUE);
  assign rif.tx_type  = tx_type_q;
  assign rif.tx_len   = tx_len_q;
  assign busy         = (state_q != ST_IDLE);
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
